acq_carrier_mixer_acc: RTL and testbench

Carrier wipe-off and coherent accumulation stage for the acquisition path. It sits directly downstream of the 3-bit sin/cos DDS. Each valid input sample is multiplied by the complex conjugate carrier (cos − j·sin), and the I/Q products are summed over a programmable number of samples. Each finished coherent sum is dumped with a one-cycle valid strobe for the correlator/detector that follows.

---
 rtl/acq_carrier_mixer_acc.sv | 131 +++++++++++++
 tb/tb_acq_carrier_mixer_acc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/acq_carrier_mixer_acc.sv
// Carrier wipe-off (x conj carrier) and coherent I/Q accumulation with per-interval dump.
// Define ACQ_MIX_SAT_EN for saturating additions with a sticky ovf flag; otherwise sums wrap.
module acq_carrier_mixer_acc #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic                        sample_valid,
  input  logic signed [2:0]           sin,
  input  logic signed [2:0]           cos,
  input  logic        [LEN_WIDTH-1:0] acc_len,
  output logic signed [ACC_WIDTH-1:0] i_out,
  output logic signed [ACC_WIDTH-1:0] q_out,
  output logic                        out_valid,
  output logic                        ovf
);

  localparam int unsigned PW = IN_WIDTH + 3;

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t                      state;
  logic                        pv_q;
  logic signed [PW-1:0]        p_i_q, p_q_q;
  logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
  logic        [LEN_WIDTH-1:0] cnt, len_q;

  logic signed [PW-1:0]        mul_i_c, mul_q_c;
  logic signed [ACC_WIDTH-1:0] ext_i_c, ext_q_c, sum_i_c, sum_q_c;
  logic                        clip_i_c, clip_q_c;

  // Mix with the conjugate carrier: I = s*cos, Q = -(s*sin)
  assign mul_i_c = PW'(sample_in) * PW'(cos);
  assign mul_q_c = -(PW'(sample_in) * PW'(sin));

  assign ext_i_c = ACC_WIDTH'(p_i_q);
  assign ext_q_c = ACC_WIDTH'(p_q_q);

`ifdef ACQ_MIX_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Returns {clipped, result}; one guard bit detects signed overflow
  function automatic logic [ACC_WIDTH:0] add_f(input logic signed [ACC_WIDTH-1:0] a,
                                               input logic signed [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] full;
    full = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (full[ACC_WIDTH] != full[ACC_WIDTH-1]) begin
      return {1'b1, (full[ACC_WIDTH] ? SAT_MIN : SAT_MAX)};
    end
    return {1'b0, full[ACC_WIDTH-1:0]};
  endfunction
`else
  function automatic logic [ACC_WIDTH:0] add_f(input logic signed [ACC_WIDTH-1:0] a,
                                               input logic signed [ACC_WIDTH-1:0] b);
    return {1'b0, a + b};
  endfunction
`endif

  assign {clip_i_c, sum_i_c} = add_f(acc_i, ext_i_c);
  assign {clip_q_c, sum_q_c} = add_f(acc_q, ext_q_c);

  // Stage 1 product capture, stage 2 accumulate/dump, IDLE/ACC control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pv_q      <= 1'b0;
      p_i_q     <= '0;
      p_q_q     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      len_q     <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      pv_q      <= en & sample_valid;
      if (en && sample_valid) begin
        p_i_q <= mul_i_c;
        p_q_q <= mul_q_c;
      end
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_ACC;
            len_q <= acc_len;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
            ovf   <= 1'b0;
          end
        end
        ST_ACC: begin
          if (!en) begin
            // Partial interval is dropped; the outputs keep the last dump
            state <= ST_IDLE;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
          end else if (pv_q) begin
            if (cnt == len_q) begin
              i_out     <= sum_i_c;
              q_out     <= sum_q_c;
              out_valid <= 1'b1;
              acc_i     <= '0;
              acc_q     <= '0;
              cnt       <= '0;
              len_q     <= acc_len;
            end else begin
              acc_i <= sum_i_c;
              acc_q <= sum_q_c;
              cnt   <= cnt + LEN_WIDTH'(1);
            end
            if (clip_i_c || clip_q_c) begin
              ovf <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_carrier_mixer_acc.sv
// Scoreboard bench for acq_carrier_mixer_acc: 16-bit and 8-bit accumulator instances on shared stimulus.
module tb_acq_carrier_mixer_acc;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                en = 1'b0;
  logic                vld = 1'b0;
  logic signed [3:0]   smp = '0;
  logic signed [2:0]   sn = '0;
  logic signed [2:0]   cs = '0;
  logic        [9:0]   len = '0;

  logic signed [15:0]  i16, q16;
  logic                v16, o16;
  logic signed [7:0]   i8, q8;
  logic                v8, o8;

  always #5 clk = ~clk;

  acq_carrier_mixer_acc dut (
    .clk(clk), .reset(reset), .en(en), .sample_in(smp), .sample_valid(vld),
    .sin(sn), .cos(cs), .acc_len(len),
    .i_out(i16), .q_out(q16), .out_valid(v16), .ovf(o16)
  );

  acq_carrier_mixer_acc #(.IN_WIDTH(4), .ACC_WIDTH(8), .LEN_WIDTH(10)) dut8 (
    .clk(clk), .reset(reset), .en(en), .sample_in(smp), .sample_valid(vld),
    .sin(sn), .cos(cs), .acc_len(len),
    .i_out(i8), .q_out(q8), .out_valid(v8), .ovf(o8)
  );

  typedef struct {
    int cyc;
    int i16, q16, i8, q8;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Model state: running interval plus the product captured on the previous edge
  bit   m_run = 0, m_pend = 0, clip_hit = 0;
  int   m_cnt = 0, m_len = 0, m_pi = 0, m_pq = 0;
  int   a16i = 0, a16q = 0, a8i = 0, a8q = 0;
  bit   m_ovf16 = 0, m_ovf8 = 0;
  int   h16i = 0, h16q = 0, h8i = 0, h8q = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int addw(input int a, input int b, input int w);
    int s, mx, mn;
    s  = a + b;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
`ifdef ACQ_MIX_SAT_EN
    if (s > mx) begin s = mx; clip_hit = 1; end
    if (s < mn) begin s = mn; clip_hit = 1; end
`else
    s = s & ((1 << w) - 1);
    if (s > mx) s = s - (1 << w);
`endif
    return s;
  endfunction

  task automatic clear_acc();
    a16i = 0; a16q = 0; a8i = 0; a8q = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    exp_t e;
    if (reset) begin
      m_run = 0; m_pend = 0; m_ovf16 = 0; m_ovf8 = 0;
      clear_acc();
      return;
    end
    if (m_pend && en && m_run) begin
      m_cnt++;
      if (m_cnt == m_len + 1) begin
        e.cyc = cyc;
        clip_hit = 0;
        e.i16 = addw(a16i, m_pi, 16); e.q16 = addw(a16q, m_pq, 16);
        if (clip_hit) m_ovf16 = 1;
        clip_hit = 0;
        e.i8 = addw(a8i, m_pi, 8); e.q8 = addw(a8q, m_pq, 8);
        if (clip_hit) m_ovf8 = 1;
        sb.push_back(e);
        clear_acc();
        m_len = int'(len);
      end else begin
        clip_hit = 0;
        a16i = addw(a16i, m_pi, 16); a16q = addw(a16q, m_pq, 16);
        if (clip_hit) m_ovf16 = 1;
        clip_hit = 0;
        a8i = addw(a8i, m_pi, 8); a8q = addw(a8q, m_pq, 8);
        if (clip_hit) m_ovf8 = 1;
      end
    end
    if (!en) begin
      m_run = 0;
      clear_acc();
    end else if (!m_run) begin
      m_run = 1; m_len = int'(len); m_ovf16 = 0; m_ovf8 = 0;
      clear_acc();
    end
    m_pend = en && vld;
    m_pi   = int'(smp) * int'(cs);
    m_pq   = -(int'(smp) * int'(sn));
  endtask

  task automatic check_cycle();
    bit exp_v;
    exp_t e;
    exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
    check_eq("valid16", int'(v16), int'(exp_v));
    check_eq("valid8", int'(v8), int'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      h16i = e.i16; h16q = e.q16; h8i = e.i8; h8q = e.q8;
    end
    check_eq("i16", int'(i16), h16i);
    check_eq("q16", int'(q16), h16q);
    check_eq("i8", int'(i8), h8i);
    check_eq("q8", int'(q8), h8q);
    check_eq("ovf16", int'(o16), int'(m_ovf16));
    check_eq("ovf8", int'(o8), int'(m_ovf8));
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
    #1;
    check_cycle();
  end

  task automatic drive(input bit e, input bit v, input int s, input int sine,
                       input int cosi, input int l);
    en = e; vld = v; smp = 4'(s); sn = 3'(sine); cs = 3'(cosi); len = 10'(l);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Steady interval: 4 samples of +1*cos3 -> I=12, Q=0
    for (int k = 0; k < 13; k++) drive(1, 1, 1, 0, 3, 3);
    idle(3);

    // Dump every sample: -2 with sin=3, cos=-1 -> I=2, Q=6
    for (int k = 0; k < 8; k++) drive(1, 1, -2, 3, -1, 0);
    idle(3);

    // Valid every other cycle, pairs summed -> I=12, Q=-6
    for (int k = 0; k < 12; k++) drive(1, k[0] == 1'b0, 3, 1, 2, 1);
    idle(3);

    // Partial interval abandoned by en drop, then a fresh 8-sample interval
    for (int k = 0; k < 5; k++) drive(1, 1, 2, 1, 1, 7);
    idle(2);
    for (int k = 0; k < 10; k++) drive(1, 1, k - 4, -2, 3, 7);
    idle(3);

    // Accumulator range: 16 x 21 exceeds the 8-bit instance
    for (int k = 0; k < 18; k++) drive(1, 1, 7, 0, 3, 15);
    idle(1);
    check_eq("ovf8_hold_after_en_drop", int'(o8), int'(m_ovf8));
    idle(2);
    // Re-entry clears ovf
    for (int k = 0; k < 3; k++) drive(1, 1, 1, 1, 1, 0);
    idle(2);

    // Randomised run with mid-interval acc_len changes and occasional en drops
    for (int k = 0; k < 250; k++) begin
      drive($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 6)) - 3,
            int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 5)));
    end
    idle(3);

    // Asynchronous reset in the middle of an interval
    for (int k = 0; k < 6; k++) drive(1, 1, 5, 1, 3, 3);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    h16i = 0; h16q = 0; h8i = 0; h8q = 0;
    check_eq("async_rst_i16", int'(i16), 0);
    check_eq("async_rst_q16", int'(q16), 0);
    check_eq("async_rst_valid", int'(v16), 0);
    check_eq("async_rst_i8", int'(i8), 0);
    check_eq("async_rst_ovf8", int'(o8), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) drive(1, 1, 2, -1, 1, 3);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
